// File: rtl/line_window_buffer.sv
// rtl/line_window_buffer.sv - raster line ring emitting one vertical window column per accepted pixel
// Optional zero padding of the top rows: define LINE_WINDOW_BUFFER_ZERO_PAD_EN.
module line_window_buffer #(
  parameter int P_COLUMNS     = 640,
  parameter int P_FRAME_ROWS  = 480,
  parameter int P_WINDOW_ROWS = 3,
  parameter int P_PIXEL_DEPTH = 24
) (
  input  logic                                   I_CLK,
  input  logic                                   I_RESET,
  input  logic [P_PIXEL_DEPTH-1:0]               I_PIXEL,
  input  logic                                   I_VALID,
  input  logic                                   I_SOF,
  output logic                                   O_READY,
  output logic [P_WINDOW_ROWS*P_PIXEL_DEPTH-1:0] O_WINDOW,
  output logic                                   O_VALID,
  input  logic                                   I_READY,
  output logic [$clog2(P_COLUMNS)-1:0]           O_COLUMN,
  output logic [$clog2(P_FRAME_ROWS)-1:0]        O_ROW,
  output logic                                   O_FRAME_DONE
);

  localparam int CW = $clog2(P_COLUMNS);
  localparam int RW = $clog2(P_FRAME_ROWS);
  localparam int D  = P_PIXEL_DEPTH;
  localparam int L  = P_WINDOW_ROWS - 1;
  localparam int HW = (L > 1) ? $clog2(L) : 1;
  localparam logic [CW-1:0] LAST_COL         = CW'(P_COLUMNS - 1);
  localparam logic [RW-1:0] LAST_ROW         = RW'(P_FRAME_ROWS - 1);
  localparam logic [RW-1:0] FIRST_STREAM_ROW = RW'(L);
  localparam logic [HW-1:0] LAST_LINE        = HW'(L - 1);

  typedef enum logic {FILL, STREAM} state_t;

  state_t                       state;
  logic [D-1:0]                 lines [L][P_COLUMNS];
  logic [CW-1:0]                col, eff_col;
  logic [RW-1:0]                row, eff_row;
  logic [HW-1:0]                head, wr_line;
  logic                         accept, emit, col_wrap, last_pixel;
  logic [P_WINDOW_ROWS*D-1:0]   window;

  // Ring index arithmetic; offsets never exceed one lap so a single subtract suffices.
  function automatic logic [HW-1:0] line_at(input logic [HW-1:0] base, input int offset);
    int s;
    s = int'(base) + offset;
    if (s >= L) s = s - L;
    return HW'(s);
  endfunction

  assign O_READY = I_READY || !O_VALID;

  always_comb begin
    accept     = I_VALID && O_READY;
    eff_col    = I_SOF ? '0 : col;
    eff_row    = I_SOF ? '0 : row;
    col_wrap   = (eff_col == LAST_COL);
    last_pixel = col_wrap && (eff_row == LAST_ROW);
    wr_line    = line_at(head, L - 1);
    window     = '0;
    window[D-1:0] = I_PIXEL;
    for (int k = 1; k < P_WINDOW_ROWS; k++)
      window[k*D +: D] = lines[line_at(head, k - 1)][eff_col];
`ifdef LINE_WINDOW_BUFFER_ZERO_PAD_EN
    emit = 1'b1;
    for (int k = 1; k < P_WINDOW_ROWS; k++)
      if (int'(eff_row) < k) window[k*D +: D] = '0;
`else
    emit = !I_SOF && (state == STREAM || (eff_col == '0 && eff_row == FIRST_STREAM_ROW));
`endif
  end

  // Line memories are never reset; stale content is overwritten while filling.
  always_ff @(posedge I_CLK) begin
    if (accept && !I_RESET) lines[wr_line][eff_col] <= I_PIXEL;
  end

  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      O_VALID      <= 1'b0;
      O_FRAME_DONE <= 1'b0;
      O_WINDOW     <= '0;
      O_COLUMN     <= '0;
      O_ROW        <= '0;
      col          <= '0;
      row          <= '0;
      head         <= '0;
      state        <= FILL;
    end else if (accept) begin
      O_VALID      <= emit;
      O_FRAME_DONE <= emit && last_pixel;
      if (emit) begin
        O_WINDOW <= window;
        O_COLUMN <= eff_col;
        O_ROW    <= eff_row;
      end
      if (col_wrap) begin
        col  <= '0;
        row  <= (eff_row == LAST_ROW) ? '0 : eff_row + 1'b1;
        head <= (head == '0) ? LAST_LINE : head - 1'b1;
      end else begin
        col <= eff_col + 1'b1;
        row <= eff_row;
      end
      if (I_SOF)
        state <= FILL;
      else if (state == FILL && eff_col == '0 && eff_row == FIRST_STREAM_ROW)
        state <= STREAM;
      else if (state == STREAM && last_pixel)
        state <= FILL;
    end else if (I_READY) begin
      O_VALID      <= 1'b0;
      O_FRAME_DONE <= 1'b0;
    end
  end

endmodule
